// File: rtl/if_id_dual_pipe_if.sv
// Fetch/decode boundary bundle for the dual-issue IF/ID pipeline register.
// Optional performance counters appear only when IFID_PERF_CNT_EN is defined.
interface if_id_dual_pipe_if;
  // fetch side
  logic [31:0] instr1_F;
  logic [31:0] instr2_F;
  logic [7:0]  pc_F;
  logic        valid_F;
  logic        valid2_F;
  logic        prediction_F;
  logic        hold_F;
  // decode control
  logic        stall_D;
  logic        flush_D;
  logic        split_D;
  // decode side
  logic [31:0] instr1_D;
  logic [31:0] instr2_D;
  logic [7:0]  pcD;
  logic [7:0]  pcPlus1D;
  logic [7:0]  pcPlus2D;
  logic        valid1_D;
  logic        valid2_D;
  logic        predictionD;
  logic        replay_D;
`ifdef IFID_PERF_CNT_EN
  logic [15:0] replay_cnt;
  logic [15:0] bubble_cnt;

  modport master (
    output instr1_F, instr2_F, pc_F, valid_F, valid2_F, prediction_F,
    output stall_D, flush_D, split_D,
    input  hold_F, instr1_D, instr2_D, pcD, pcPlus1D, pcPlus2D,
    input  valid1_D, valid2_D, predictionD, replay_D,
    input  replay_cnt, bubble_cnt
  );

  modport slave (
    input  instr1_F, instr2_F, pc_F, valid_F, valid2_F, prediction_F,
    input  stall_D, flush_D, split_D,
    output hold_F, instr1_D, instr2_D, pcD, pcPlus1D, pcPlus2D,
    output valid1_D, valid2_D, predictionD, replay_D,
    output replay_cnt, bubble_cnt
  );
`else
  modport master (
    output instr1_F, instr2_F, pc_F, valid_F, valid2_F, prediction_F,
    output stall_D, flush_D, split_D,
    input  hold_F, instr1_D, instr2_D, pcD, pcPlus1D, pcPlus2D,
    input  valid1_D, valid2_D, predictionD, replay_D
  );

  modport slave (
    input  instr1_F, instr2_F, pc_F, valid_F, valid2_F, prediction_F,
    input  stall_D, flush_D, split_D,
    output hold_F, instr1_D, instr2_D, pcD, pcPlus1D, pcPlus2D,
    output valid1_D, valid2_D, predictionD, replay_D
  );
`endif
endinterface

// File: rtl/if_id_dual_pipe.sv
// Dual-issue IF/ID pipeline register. When decode can only issue slot 1
// (split), the slot-2 word is replayed as slot 1 on the next cycle while
// fetch is held. Optional replay/bubble counters: define IFID_PERF_CNT_EN.
module if_id_dual_pipe (
  input  logic          clk,
  input  logic          reset,
  if_id_dual_pipe_if.slave bus
);

  typedef enum logic {
    NORMAL = 1'b0,
    REPLAY = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0] instr1;
    logic [31:0] instr2;
    logic [7:0]  pc;
    logic        valid1;
    logic        valid2;
    logic        prediction;
    logic        replay;
  } dec_t;

  state_t state_q, state_n;
  dec_t   dec_q, dec_n;

  logic split_go;

  // A split only matters when there is a real slot-2 word to replay.
  assign split_go = (state_q == NORMAL) && bus.split_D && dec_q.valid2;

  // State and decode register update; reset wins over everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q <= NORMAL;
      dec_q   <= '0;
    end else begin
      state_q <= state_n;
      dec_q   <= dec_n;
    end
  end

  // Next-state and next register contents: flush > stall > split > load.
  always_comb begin
    // NOTE: defaults first so every path assigns every bit and no latch forms.
    state_n = state_q;
    dec_n   = dec_q;
    if (bus.flush_D) begin
      state_n = NORMAL;
      dec_n   = '0;
    end else if (bus.stall_D) begin
      state_n = state_q;
      dec_n   = dec_q;
    end else if (split_go) begin
      state_n          = REPLAY;
      dec_n.instr1     = dec_q.instr2;
      dec_n.instr2     = '0;
      dec_n.pc         = dec_q.pc + 8'd1;
      dec_n.valid1     = 1'b1;
      dec_n.valid2     = 1'b0;
      dec_n.prediction = 1'b0;
      dec_n.replay     = 1'b1;
    end else begin
      state_n          = NORMAL;
      dec_n.instr1     = bus.instr1_F;
      dec_n.instr2     = bus.instr2_F;
      dec_n.pc         = bus.pc_F;
      dec_n.valid1     = bus.valid_F;
      dec_n.valid2     = bus.valid_F & bus.valid2_F;
      dec_n.prediction = bus.prediction_F;
      dec_n.replay     = 1'b0;
    end
  end

  // Fetch must hold whenever this register will not capture its pair;
  // a flush always lets fetch move on.
  assign bus.hold_F = ~bus.flush_D &
                      (bus.stall_D | split_go | (state_q == REPLAY));

  assign bus.instr1_D    = dec_q.instr1;
  assign bus.instr2_D    = dec_q.instr2;
  assign bus.pcD         = dec_q.pc;
  assign bus.pcPlus1D    = dec_q.pc + 8'd1;
  assign bus.pcPlus2D    = dec_q.pc + 8'd2;
  assign bus.valid1_D    = dec_q.valid1;
  assign bus.valid2_D    = dec_q.valid2;
  assign bus.predictionD = dec_q.prediction;
  assign bus.replay_D    = dec_q.replay;

`ifdef IFID_PERF_CNT_EN
  logic [15:0] replay_cnt_q;
  logic [15:0] bubble_cnt_q;

  // Saturating performance counters, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      replay_cnt_q <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if ((state_q == REPLAY) && !bus.stall_D && (replay_cnt_q != 16'hFFFF))
        replay_cnt_q <= replay_cnt_q + 16'd1;
      if (!dec_q.valid1 && !bus.stall_D && (bubble_cnt_q != 16'hFFFF))
        bubble_cnt_q <= bubble_cnt_q + 16'd1;
    end
  end

  assign bus.replay_cnt = replay_cnt_q;
  assign bus.bubble_cnt = bubble_cnt_q;
`else
  // Counters not built.
`endif

endmodule

// File: tb/tb_if_id_dual_pipe.sv
// Directed self-checking bench for if_id_dual_pipe: reset, load, split and
// replay, stall in replay, flush priority, ignored split, PC wrap.
module tb_if_id_dual_pipe;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  if_id_dual_pipe_if bus();

  if_id_dual_pipe dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] A = 32'hAAAA_0001, B = 32'hBBBB_0002;
  localparam logic [31:0] C = 32'hCCCC_0003, D = 32'hDDDD_0004;
  localparam logic [31:0] E = 32'hEEEE_0005, F = 32'hFFFF_0006;
  localparam logic [31:0] G = 32'h1111_0007, H = 32'h2222_0008;
  localparam logic [31:0] I = 32'h3333_0009, J = 32'h4444_000A;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [7:0] pc, input logic [31:0] w1, input logic [31:0] w2,
                       input logic v, input logic v2, input logic pred);
    bus.pc_F = pc; bus.instr1_F = w1; bus.instr2_F = w2;
    bus.valid_F = v; bus.valid2_F = v2; bus.prediction_F = pred;
  endtask

  task automatic ctrl(input logic stall, input logic flush, input logic split);
    bus.stall_D = stall; bus.flush_D = flush; bus.split_D = split;
  endtask

`ifdef IFID_PERF_CNT_EN
  logic [15:0] rc0;
`endif

  initial begin
    // Reset with random fetch data and controls
    reset = 1'b1;
    fetch(8'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
    ctrl(1'($urandom), 1'($urandom), 1'($urandom));
    tick();
    reset = 1'b0;
    ctrl(0, 0, 0);
    fetch(8'h10, A, B, 1, 1, 1);
    #1;
    chk("rst_instr1", bus.instr1_D, 0);
    chk("rst_instr2", bus.instr2_D, 0);
    chk("rst_pc", bus.pcD, 0);
    chk("rst_pc1", bus.pcPlus1D, 1);
    chk("rst_pc2", bus.pcPlus2D, 2);
    chk("rst_v1", bus.valid1_D, 0);
    chk("rst_v2", bus.valid2_D, 0);
    chk("rst_pred", bus.predictionD, 0);
    chk("rst_replay", bus.replay_D, 0);
    chk("rst_hold", bus.hold_F, 0);
`ifdef IFID_PERF_CNT_EN
    chk("rst_rcnt", bus.replay_cnt, 0);
`endif

    // Normal load A/B at 0x10
    tick();
    chk("ld_pc", bus.pcD, 8'h10);
    chk("ld_pc1", bus.pcPlus1D, 8'h11);
    chk("ld_pc2", bus.pcPlus2D, 8'h12);
    chk("ld_i1", bus.instr1_D, A);
    chk("ld_i2", bus.instr2_D, B);
    chk("ld_v1", bus.valid1_D, 1);
    chk("ld_v2", bus.valid2_D, 1);
    chk("ld_pred", bus.predictionD, 1);
    chk("ld_replay", bus.replay_D, 0);

    // Split: fetch presents C/D, which must wait
    fetch(8'h12, C, D, 1, 1, 0);
    ctrl(0, 0, 1);
    #1;
    chk("sp_hold_now", bus.hold_F, 1);
    tick();
    chk("sp_i1", bus.instr1_D, B);
    chk("sp_i2", bus.instr2_D, 0);
    chk("sp_pc", bus.pcD, 8'h11);
    chk("sp_v1", bus.valid1_D, 1);
    chk("sp_v2", bus.valid2_D, 0);
    chk("sp_pred", bus.predictionD, 0);
    chk("sp_replay", bus.replay_D, 1);
    chk("sp_hold", bus.hold_F, 1);

    // Stall three cycles in REPLAY
    ctrl(1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("st_i1", bus.instr1_D, B);
      chk("st_pc", bus.pcD, 8'h11);
      chk("st_replay", bus.replay_D, 1);
      chk("st_hold", bus.hold_F, 1);
    end

    // Release: held pair C/D captured
    ctrl(0, 0, 0);
    #1;
    chk("rel_hold", bus.hold_F, 1);
    tick();
    chk("cd_i1", bus.instr1_D, C);
    chk("cd_i2", bus.instr2_D, D);
    chk("cd_pc", bus.pcD, 8'h12);
    chk("cd_v2", bus.valid2_D, 1);
    chk("cd_replay", bus.replay_D, 0);
    chk("cd_hold", bus.hold_F, 0);

    // Slot-2 invalid pair, then split must be ignored
    fetch(8'h20, E, F, 1, 0, 0);
    tick();
    chk("e_v2", bus.valid2_D, 0);
    chk("e_i2", bus.instr2_D, F);
    fetch(8'h30, G, H, 1, 1, 0);
    ctrl(0, 0, 1);
    #1;
    chk("ign_hold", bus.hold_F, 0);
    tick();
    chk("ign_pc", bus.pcD, 8'h30);
    chk("ign_i1", bus.instr1_D, G);
    chk("ign_replay", bus.replay_D, 0);

    // Enter REPLAY with H, then flush with stall and split asserted
    tick();
    chk("r2_i1", bus.instr1_D, H);
    chk("r2_pc", bus.pcD, 8'h31);
    ctrl(1, 1, 1);
    #1;
    chk("fl_hold_now", bus.hold_F, 0);
    tick();
    chk("fl_v1", bus.valid1_D, 0);
    chk("fl_i1", bus.instr1_D, 0);
    chk("fl_pc", bus.pcD, 0);
    chk("fl_replay", bus.replay_D, 0);
    ctrl(0, 0, 0);
    #1;
    chk("fl_state_normal", bus.hold_F, 0);

    // PC wrap through a split
    fetch(8'hFF, I, J, 1, 1, 1);
    tick();
    chk("wr_pc", bus.pcD, 8'hFF);
    chk("wr_pc1", bus.pcPlus1D, 8'h00);
    chk("wr_pc2", bus.pcPlus2D, 8'h01);
`ifdef IFID_PERF_CNT_EN
    rc0 = bus.replay_cnt;
`endif
    fetch(8'h40, C, D, 1, 1, 0);
    ctrl(0, 0, 1);
    tick();
    chk("wr_rpc", bus.pcD, 8'h00);
    chk("wr_ri1", bus.instr1_D, J);
    chk("wr_rpc2", bus.pcPlus2D, 8'h02);
    ctrl(0, 0, 0);
    tick();
    chk("wr_after_pc", bus.pcD, 8'h40);
`ifdef IFID_PERF_CNT_EN
    chk("wr_rcnt", bus.replay_cnt, 32'(rc0) + 1);
`endif

    // Reset mid-REPLAY discards the replayed word
    ctrl(0, 0, 1);
    tick();
    chk("mr_replay", bus.replay_D, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ctrl(0, 0, 0);
    #1;
    chk("mr_v1", bus.valid1_D, 0);
    chk("mr_i1", bus.instr1_D, 0);
    chk("mr_replay0", bus.replay_D, 0);
    chk("mr_hold", bus.hold_F, 0);
`ifdef IFID_PERF_CNT_EN
    chk("mr_rcnt", bus.replay_cnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
